// File: rtl/wb_gpio_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wb_gpio_if                                                 |
// | Description : Wishbone classic bus bundle between the conbus master and  |
// |               the GPIO slave.                                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface wb_gpio_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_gpio.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wb_gpio                                                    |
// | Description : Wishbone GPIO slave: registered LED outputs, synchronized  |
// |               (optionally debounced) inputs, maskable edge interrupt.    |
// |               Define WB_GPIO_DEBOUNCE_EN to build the debouncer.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module wb_gpio #(
  parameter int CLK_FREQ        = 100000000,
  parameter int IN_WIDTH        = 9,
  parameter int OUT_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = CLK_FREQ / 1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  wb_gpio_if.slave             wb,
  input  logic [IN_WIDTH-1:0]  gpio_i,
  output logic [OUT_WIDTH-1:0] gpio_o,
  output logic                 intr
);

  localparam logic [2:0] c_idx_in   = 3'd0;
  localparam logic [2:0] c_idx_out  = 3'd1;
  localparam logic [2:0] c_idx_mask = 3'd2;
  localparam logic [2:0] c_idx_pend = 3'd3;
  localparam logic [2:0] c_idx_rise = 3'd4;

  logic [IN_WIDTH-1:0]  s1_q, s1_d, s2_q, s2_d;
  logic [IN_WIDTH-1:0]  in_dly_q, in_dly_d;
  logic [IN_WIDTH-1:0]  pend_q, pend_d, mask_q, mask_d, rise_q, rise_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic [31:0]          dat_q, dat_d;
  logic                 ack_q, ack_d, intr_q, intr_d;

  logic [IN_WIDTH-1:0]  w_in_val;
  logic [IN_WIDTH-1:0]  w_event, w_w1c;
  logic                 w_req, w_wr, w_rd;
  logic [2:0]           w_idx;
  logic [31:0]          w_wmask, w_wbits, w_rdata;
  logic                 unused_bits;

  assign unused_bits = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0], wb.wb_dat_i, w_wmask, w_wbits};

`ifdef WB_GPIO_DEBOUNCE_EN
  localparam int c_tick_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_tick_w-1:0] c_tick_max = c_tick_w'(DEBOUNCE_CYCLES - 1);

  logic [c_tick_w-1:0] tick_q, tick_d;
  logic [IN_WIDTH-1:0] smp_q, smp_d, in_q, in_d;
  logic                w_wrap;
  logic [IN_WIDTH-1:0] w_same;

  // Sample period counter; a bit is accepted only after two equal samples.
  always_comb begin
    w_wrap = (tick_q == c_tick_max);
    tick_d = w_wrap ? '0 : tick_q + c_tick_w'(1);
    w_same = ~(s2_q ^ smp_q);
    smp_d  = smp_q;
    in_d   = in_q;
    if (w_wrap) begin
      smp_d = s2_q;
      in_d  = (in_q & ~w_same) | (s2_q & w_same);
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q <= '0;
      smp_q  <= '0;
      in_q   <= '0;
    end else begin
      tick_q <= tick_d;
      smp_q  <= smp_d;
      in_q   <= in_d;
    end
  end

  assign w_in_val = in_q;
`else
  assign w_in_val = s2_q;
`endif

  // Bus decode, register updates, edge detection and interrupt aggregation.
  always_comb begin
    w_idx   = wb.wb_adr_i[4:2];
    w_req   = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
    w_wr    = w_req & wb.wb_we_i;
    w_rd    = w_req & ~wb.wb_we_i;
    w_wmask = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
               {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
    w_wbits = wb.wb_dat_i & w_wmask;

    w_rdata = '0;
    case (w_idx)
      c_idx_in:   w_rdata[IN_WIDTH-1:0]  = w_in_val;
      c_idx_out:  w_rdata[OUT_WIDTH-1:0] = out_q;
      c_idx_mask: w_rdata[IN_WIDTH-1:0]  = mask_q;
      c_idx_pend: w_rdata[IN_WIDTH-1:0]  = pend_q;
      c_idx_rise: w_rdata[IN_WIDTH-1:0]  = rise_q;
      default:    w_rdata = '0;
    endcase

    out_d  = out_q;
    mask_d = mask_q;
    rise_d = rise_q;
    w_w1c  = '0;
    if (w_wr) begin
      case (w_idx)
        c_idx_out:  out_d  = (out_q & ~w_wmask[OUT_WIDTH-1:0]) | w_wbits[OUT_WIDTH-1:0];
        c_idx_mask: mask_d = (mask_q & ~w_wmask[IN_WIDTH-1:0]) | w_wbits[IN_WIDTH-1:0];
        c_idx_pend: w_w1c  = w_wbits[IN_WIDTH-1:0];
        c_idx_rise: rise_d = (rise_q & ~w_wmask[IN_WIDTH-1:0]) | w_wbits[IN_WIDTH-1:0];
        default:    out_d  = out_q;
      endcase
    end

    // A new edge beats a simultaneous clear so no event is ever lost.
    w_event  = (rise_q & w_in_val & ~in_dly_q) | (~rise_q & ~w_in_val & in_dly_q);
    pend_d   = (pend_q & ~w_w1c) | w_event;
    intr_d   = |(pend_q & mask_q);
    in_dly_d = w_in_val;
    s1_d     = gpio_i;
    s2_d     = s1_q;
    ack_d    = w_req;
    dat_d    = w_rd ? w_rdata : dat_q;
  end

  // Main state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      in_dly_q <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      rise_q   <= '1;
      out_q    <= '0;
      dat_q    <= '0;
      ack_q    <= 1'b0;
      intr_q   <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      in_dly_q <= in_dly_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      rise_q   <= rise_d;
      out_q    <= out_d;
      dat_q    <= dat_d;
      ack_q    <= ack_d;
      intr_q   <= intr_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign gpio_o      = out_q;
  assign intr        = intr_q;

endmodule
`default_nettype wire
